inst_loader: RTL
================

Name: inst_loader

Overview:
- Program loader: the writer side of the 128x16 instruction memory that the control unit fetches from.
- Receives a framed byte stream from a host over a valid/ready handshake.
- Assembles 16-bit instruction words, writes them sequentially from address 0, and verifies an XOR checksum.
- Holds the processor in reset until a complete, valid program is loaded.

Parameters:
- ADDR_W, 7, instruction memory address width (matches 7-bit PC).
- DATA_W, 16, instruction width; fixed at 2 bytes, big-endian.
- DEPTH, 128, maximum instructions per frame; equals 2**ADDR_W.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin new load; honoured only in IDLE, DONE or ERR.
- In_Data  input  8  host byte.
- In_Valid  input  1  host byte valid.
- In_Ready  output  1  loader accepts a byte; a transfer occurs when In_Valid && In_Ready at posedge.
- Mem_Wr  output  1  one-cycle instruction memory write strobe.
- Mem_Addr  output  ADDR_W  write address.
- Mem_Data  output  DATA_W  write data.
- Proc_Hold  output  1  active-high hold/reset to the control unit (drives its ResetN inverted).
- Busy  output  1  frame in progress.
- Done  output  1  sticky; last frame loaded and checksum matched.
- Error  output  1  sticky; last frame rejected.
- Loaded  output  8  number of words written in current/last frame (0..128).

Behaviour:
- Reset (synchronous; takes priority over everything, including mid-frame):
  - state=IDLE; Proc_Hold=1; In_Ready=0; Mem_Wr=0; Mem_Addr=0; Mem_Data=0; Busy=0; Done=0; Error=0; Loaded=0; checksum accumulator=0.
  - Memory contents are not cleared.
- Frame format: LEN byte L, then 2L data bytes (high byte then low byte per word), then CHK byte.
  - CHK = XOR of the 2L data bytes; the LEN byte is excluded.
- States: IDLE, LEN, HI, LO, CHK, DONE, ERR.
- IDLE/DONE/ERR, Start=1 → LEN:
  - Proc_Hold=1, Busy=1, Done=0, Error=0, Loaded=0, accumulator=0, word index=0.
  - Start in LEN/HI/LO/CHK is ignored.
- In_Ready=1 exactly in LEN, HI, LO, CHK; 0 otherwise. Bytes offered while In_Ready=0 are not consumed.
- LEN, byte accepted:
  - L=0 or L>DEPTH → ERR.
  - Otherwise latch L → HI.
- HI, byte accepted: latch high byte, XOR into accumulator → LO.
- LO, byte accepted: XOR into accumulator.
  - Next cycle: Mem_Wr=1 for exactly one cycle, Mem_Addr=word index, Mem_Data={high,low}; Loaded increments in that same cycle.
  - Write latency is 1 cycle after the LO transfer.
  - Word index increments after the write; it never wraps, because L≤DEPTH bounds it to DEPTH-1.
  - If words written == L → CHK, else → HI.
- CHK, byte accepted:
  - Byte equals accumulator → DONE, else → ERR.
  - Decision is registered: Done or Error rises the cycle after the CHK transfer.
- DONE: Busy=0, Done=1, Proc_Hold=0. Hold releases on the same edge Done rises.
- ERR: Busy=0, Error=1, Proc_Hold=1. Words already written stay in memory.
- In_Valid may drop for any number of cycles in any receiving state; state and accumulator hold.
- Mem_Wr is never asserted outside the cycle after a LO transfer.
- Back-to-back bytes at full rate are supported. The pending write in the cycle after LO does not stall acceptance of the next HI byte.

Test Plan:
- Reset → Proc_Hold=1, In_Ready=0, Mem_Wr=0, Busy=0, Done=0, Error=0, Loaded=0.
- Start; bytes 02,12,34,AB,CD,40 at full rate → Mem_Wr pulses (addr 0, 1234) then (addr 1, ABCD), each 1 cycle after its LO byte. Then Done=1, Proc_Hold=0, Loaded=2, Busy=0.
- Same frame with CHK=41 → both writes still occur; Error=1, Done=0, Proc_Hold=1. A later Start followed by the correct frame → Done=1, Error=0.
- LEN=00 → Error=1 after 1 byte, no Mem_Wr. Separately, LEN=81 → Error=1, no Mem_Wr.
- LEN=80 with 256 data bytes (word k = {k, ~k}) and the correct CHK → 128 writes, last at Mem_Addr=7F. Loaded=128, Done=1, no address wrap.
- Mid-frame checks:
  - In_Valid gaps of 3 cycles between bytes → identical writes and result.
  - Start pulsed in HI → ignored.
  - Reset after word 0 is written → IDLE, Proc_Hold=1, Loaded=0, no further Mem_Wr.

Source files
------------

// File: rtl/inst_loader_if.sv
// Host-to-loader byte stream: valid/ready handshake carrying one program byte per transfer.
interface inst_loader_if;
  logic [7:0] In_Data;
  logic       In_Valid;
  logic       In_Ready;

  modport master (output In_Data, output In_Valid, input In_Ready);
  modport slave  (input In_Data, input In_Valid, output In_Ready);
endinterface

// File: rtl/inst_loader.sv
// Program loader: receives LEN / 2L data bytes / CHK frames, writes 16-bit words
// sequentially into instruction memory and holds the processor until a frame verifies.
module inst_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  inst_loader_if.slave      host,
  output logic              Mem_Wr,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Proc_Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [7:0]        Loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t              r_state, w_next;
  logic [7:0]          r_len, r_hi, r_acc, r_loaded;
  logic                r_wr, r_hold, r_busy, r_done, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                w_xfer, w_start_ok, w_len_bad, w_last, w_chk_ok;

  assign host.In_Ready = (r_state == S_LEN) || (r_state == S_HI) ||
                         (r_state == S_LO)  || (r_state == S_CHK);
  assign w_xfer     = host.In_Valid && host.In_Ready;
  assign w_start_ok = Start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_len_bad  = (host.In_Data == 8'd0) || ({1'b0, host.In_Data} > DEPTH_L);
  // r_loaded still holds the pre-increment count during the LO transfer
  assign w_last     = (r_loaded + 8'd1) == r_len;
  assign w_chk_ok   = host.In_Data == r_acc;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (Start)  w_next = S_LEN;
      S_LEN: if (w_xfer) w_next = w_len_bad ? S_ERR : S_HI;
      S_HI:  if (w_xfer) w_next = S_LO;
      S_LO:  if (w_xfer) w_next = w_last ? S_CHK : S_HI;
      S_CHK: if (w_xfer) w_next = w_chk_ok ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_len    <= '0;
      r_hi     <= '0;
      r_acc    <= '0;
      r_loaded <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_hold   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (w_start_ok) begin
        r_hold   <= 1'b1;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
        r_err    <= 1'b0;
        r_loaded <= '0;
        r_acc    <= '0;
      end
      if (w_xfer) begin
        case (r_state)
          S_LEN: begin
            if (w_len_bad) begin
              r_err  <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_len <= host.In_Data;
            end
          end
          S_HI: begin
            r_hi  <= host.In_Data;
            r_acc <= r_acc ^ host.In_Data;
          end
          S_LO: begin
            r_acc    <= r_acc ^ host.In_Data;
            r_wr     <= 1'b1;
            r_addr   <= r_loaded[ADDR_W-1:0];
            r_data   <= DATA_W'({r_hi, host.In_Data});
            r_loaded <= r_loaded + 8'd1;
          end
          S_CHK: begin
            r_busy <= 1'b0;
            if (w_chk_ok) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Mem_Wr    = r_wr;
  assign Mem_Addr  = r_addr;
  assign Mem_Data  = r_data;
  assign Proc_Hold = r_hold;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Error     = r_err;
  assign Loaded    = r_loaded;

endmodule
